cache_miss_controller: RTL and testbench

//  Sequencing FSM for the direct-mapped cache: accepts word reads from a requester, consults the

---
 rtl/cache_pkg.sv | 26 ++
 rtl/sat_counter.sv | 33 +++
 rtl/cache_miss_controller.sv | 155 +++++++++++++++
 tb/tb_cache_miss_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and line-select helper for the direct-mapped cache controller.
package cache_pkg;

  localparam int unsigned OFFSET_W  = 2;
  localparam int unsigned INDEX_W   = 10;
  localparam int unsigned TAG_W     = 3;
  localparam int unsigned ADDR_W    = TAG_W + INDEX_W + OFFSET_W;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LINE_W    = WORD_W << OFFSET_W;
  localparam int unsigned NUM_LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMem,
    StFill,
    StResp,
    StFlush
  } state_e;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]   line,
                                                  input logic [OFFSET_W-1:0] offset);
    return line[WORD_W*offset +: WORD_W];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_miss_controller.sv
// Read-miss sequencer for the direct-mapped cache: lookup, line fetch and fill, response
// handshake, full-array invalidate, and saturating hit/miss statistics.
module cache_miss_controller
  import cache_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_W-1:0]    req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [WORD_W-1:0]    resp_data_o,
  output logic                 resp_hit_o,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic [ADDR_W-1:0]    dp_addr_o,
  input  logic                 dp_hit_i,
  input  logic [WORD_W-1:0]    dp_word_i,
  output logic                 fill_en_o,
  output logic                 inv_en_o,
  output logic [INDEX_W-1:0]   inv_index_o,
  output logic                 mem_read_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic [LINE_W-1:0]    mem_rdata_i,
  output logic [CNT_W-1:0]     hit_count_o,
  output logic [CNT_W-1:0]     miss_count_o
);

  localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               hit_q, hit_d;
  logic [LatW-1:0]    wait_q, wait_d;
  logic [INDEX_W-1:0] inv_q, inv_d;
  logic               hit_inc, miss_inc, stat_clr;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    hit_d    = hit_q;
    wait_d   = wait_q;
    inv_d    = inv_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    stat_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Flush wins over a coincident request.
        if (flush_i) begin
          inv_d    = '0;
          stat_clr = 1'b1;
          state_d  = StFlush;
        end else if (req_valid_i) begin
          addr_d  = req_addr_i;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (dp_hit_i) begin
          data_d  = dp_word_i;
          hit_d   = 1'b1;
          hit_inc = 1'b1;
          state_d = StResp;
        end else begin
          miss_inc = 1'b1;
          wait_d   = LatW'(MEM_LAT - 1);
          state_d  = StMem;
        end
      end
      StMem: begin
        if (wait_q == '0) begin
          state_d = StFill;
        end else begin
          wait_d = wait_q - LatW'(1);
        end
      end
      StFill: begin
        data_d  = line_word(mem_rdata_i, addr_q[OFFSET_W-1:0]);
        hit_d   = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        inv_d = inv_q + INDEX_W'(1);
        if (inv_q == INDEX_W'(NUM_LINES - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      hit_q   <= 1'b0;
      wait_q  <= '0;
      inv_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hit_q   <= hit_d;
      wait_q  <= wait_d;
      inv_q   <= inv_d;
    end
  end

  // All handshake and strobe outputs are pure decodes of the registered state.
  assign req_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign fill_en_o    = (state_q == StFill);
  assign inv_en_o     = (state_q == StFlush);
  assign mem_read_o   = (state_q == StMem);
  assign inv_index_o  = inv_q;
  assign dp_addr_o    = addr_q;
  assign mem_addr_o   = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign resp_data_o  = data_q;
  assign resp_hit_o   = hit_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (hit_inc),
    .clr_i (stat_clr),
    .cnt_o (hit_count_o)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_miss_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (miss_inc),
    .clr_i (stat_clr),
    .cnt_o (miss_count_o)
  );

endmodule

// File: tb/tb_cache_miss_controller.sv
// Bench for cache_miss_controller: directed vector table, corner sequences, and random reads
// checked against a set-of-lines cache model. Instance a: MEM_LAT=1/CNT_W=16, b: MEM_LAT=4/CNT_W=4.
module tb_cache_miss_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, resp_ready, flush;
  logic [14:0]  req_addr;
  logic         dp_hit;
  logic [31:0]  dp_word;
  logic [127:0] mem_rdata;

  logic         a_req_ready, a_resp_valid, a_resp_hit, a_busy, a_fill_en, a_inv_en, a_mem_read;
  logic [31:0]  a_resp_data;
  logic [14:0]  a_dp_addr, a_mem_addr;
  logic [9:0]   a_inv_index;
  logic [15:0]  a_hit_count, a_miss_count;

  logic         b_req_ready, b_resp_valid, b_resp_hit, b_busy, b_fill_en, b_inv_en, b_mem_read;
  logic [31:0]  b_resp_data;
  logic [14:0]  b_dp_addr, b_mem_addr;
  logic [9:0]   b_inv_index;
  logic [3:0]   b_hit_count, b_miss_count;

  always #5 clk = ~clk;

  cache_miss_controller #(.MEM_LAT(1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(a_req_ready),
    .req_addr_i(req_addr), .resp_valid_o(a_resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(a_resp_data), .resp_hit_o(a_resp_hit), .flush_i(flush), .busy_o(a_busy),
    .dp_addr_o(a_dp_addr), .dp_hit_i(dp_hit), .dp_word_i(dp_word), .fill_en_o(a_fill_en),
    .inv_en_o(a_inv_en), .inv_index_o(a_inv_index), .mem_read_o(a_mem_read),
    .mem_addr_o(a_mem_addr), .mem_rdata_i(mem_rdata), .hit_count_o(a_hit_count),
    .miss_count_o(a_miss_count)
  );

  cache_miss_controller #(.MEM_LAT(4), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(b_req_ready),
    .req_addr_i(req_addr), .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(b_resp_data), .resp_hit_o(b_resp_hit), .flush_i(flush), .busy_o(b_busy),
    .dp_addr_o(b_dp_addr), .dp_hit_i(dp_hit), .dp_word_i(dp_word), .fill_en_o(b_fill_en),
    .inv_en_o(b_inv_en), .inv_index_o(b_inv_index), .mem_read_o(b_mem_read),
    .mem_addr_o(b_mem_addr), .mem_rdata_i(mem_rdata), .hit_count_o(b_hit_count),
    .miss_count_o(b_miss_count)
  );

  int errors = 0;
  int checks = 0;

  // Datapath/memory environment: either forced values or an emulated cache array behind dut_a.
  logic         model_mode;
  logic         force_hit;
  logic [31:0]  force_word;
  logic [127:0] fixed_line;
  logic         env_valid [1024];
  logic [2:0]   env_tag   [1024];
  logic [127:0] env_line  [1024];
  logic [127:0] env_sel;

  function automatic logic [31:0] gen_word(input logic [12:0] la, input logic [1:0] k);
    return {6'h2A, k, 11'h0, la};
  endfunction

  function automatic logic [127:0] gen_line(input logic [12:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = gen_word(la, 2'(k));
    return l;
  endfunction

  always_comb begin
    dp_hit    = force_hit;
    dp_word   = force_word;
    mem_rdata = fixed_line;
    env_sel   = env_line[a_dp_addr[11:2]];
    if (model_mode) begin
      dp_hit    = env_valid[a_dp_addr[11:2]] && (env_tag[a_dp_addr[11:2]] == a_dp_addr[14:12]);
      dp_word   = env_sel[32*a_dp_addr[1:0] +: 32];
      mem_rdata = gen_line(a_mem_addr[14:2]);
    end
  end

  always @(posedge clk) begin
    if (a_fill_en) begin
      env_valid[a_dp_addr[11:2]] <= 1'b1;
      env_tag[a_dp_addr[11:2]]   <= a_dp_addr[14:12];
      env_line[a_dp_addr[11:2]]  <= mem_rdata;
    end
    if (a_inv_en) env_valid[a_inv_index] <= 1'b0;
  end

  // Reference model state: which lines the cache should hold, and expected statistics.
  logic        ref_valid [1024];
  logic [2:0]  ref_tag   [1024];
  int          ref_hits, ref_misses;
  logic [14:0] last_addr;

  typedef struct {
    logic [14:0]  addr;
    logic         hit;
    logic [31:0]  word;
    logic [127:0] line;
    logic [31:0]  exp_data;
    logic         exp_hit;
    int unsigned  delay;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0; req_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    last_addr = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!a_req_ready && n < 3000) begin
      tick();
      n++;
    end
    chk("wait_idle", 32'(a_req_ready), 32'd1);
  endtask

  // One read on dut_a; cycle N below is the N-th edge after the accept edge, i.e. the edge
  // at which the requester first samples resp_valid high.
  task automatic run_txn(input string nm, input logic [14:0] addr, input int unsigned delay,
                         input logic exp_hit, input logic [31:0] exp_data);
    int cyc, mem_cyc, fill_cyc, bad;
    wait_idle();
    req_addr = addr; req_valid = 1'b1; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    last_addr = addr;
    chk({nm, "_dp_addr"}, 32'(a_dp_addr), 32'(addr));
    cyc = 0; mem_cyc = 0; fill_cyc = 0; bad = 0;
    while (!a_resp_valid && cyc < 40) begin
      if (a_mem_read) begin
        mem_cyc++;
        if (a_mem_addr != {addr[14:2], 2'b00}) bad++;
      end
      if (a_fill_en) fill_cyc++;
      tick();
      cyc++;
    end
    chk({nm, "_latency"}, 32'(cyc + 1), exp_hit ? 32'd2 : 32'd4);
    chk({nm, "_resp_hit"}, 32'(a_resp_hit), 32'(exp_hit));
    chk({nm, "_resp_data"}, a_resp_data, exp_data);
    chk({nm, "_mem_cycles"}, 32'(mem_cyc), exp_hit ? 32'd0 : 32'd1);
    chk({nm, "_fill_cycles"}, 32'(fill_cyc), exp_hit ? 32'd0 : 32'd1);
    chk({nm, "_mem_addr_bad"}, 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < int'(delay); i++) begin
      tick();
      if (!a_resp_valid || a_resp_data != exp_data || a_req_ready) bad++;
    end
    if (delay > 0) chk({nm, "_hold_bad"}, 32'(bad), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({nm, "_back_idle"}, 32'(a_req_ready), 32'd1);
  endtask

  task automatic do_flush(input logic with_req, input logic [14:0] keep_addr);
    int bad_en, bad_idx, bad_rdy;
    wait_idle();
    flush = 1'b1;
    if (with_req) begin
      req_valid = 1'b1;
      req_addr  = 15'h7ABC;
    end
    tick();
    flush = 1'b0;
    bad_en = 0; bad_idx = 0; bad_rdy = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!a_inv_en) bad_en++;
      if (a_inv_index != 10'(i)) bad_idx++;
      if (a_req_ready) bad_rdy++;
      if (i == 10) req_valid = 1'b0;
      flush = (i == 500);
      tick();
    end
    flush = 1'b0;
    chk("flush_inv_en_bad", 32'(bad_en), 32'd0);
    chk("flush_index_bad", 32'(bad_idx), 32'd0);
    chk("flush_ready_bad", 32'(bad_rdy), 32'd0);
    chk("flush_end_idle", 32'({a_busy, a_inv_en, a_req_ready}), 32'b001);
    chk("flush_hit_cnt", 32'(a_hit_count), 32'd0);
    chk("flush_miss_cnt", 32'(a_miss_count), 32'd0);
    chk("flush_req_ignored", 32'(a_dp_addr), 32'(keep_addr));
  endtask

  initial begin
    vecs[0] = '{15'h0402, 1'b0, 32'h0,
                {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA},
                32'hCCCC_CCCC, 1'b0, 0};
    vecs[1] = '{15'h1234, 1'b1, 32'hDEAD_BEEF, 128'h0, 32'hDEAD_BEEF, 1'b1, 0};
    vecs[2] = '{15'h7FFF, 1'b0, 32'h0,
                {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000},
                32'h3333_3333, 1'b0, 5};
    vecs[3] = '{15'h0000, 1'b0, 32'h0, {96'h0, 32'h0BAD_F00D}, 32'h0BAD_F00D, 1'b0, 1};
    vecs[4] = '{15'h5555, 1'b1, 32'h1234_5678, 128'h0, 32'h1234_5678, 1'b1, 2};
    vecs[5] = '{15'h2001, 1'b0, 32'h0, {64'h0, 32'hCAFE_0001, 32'h0}, 32'hCAFE_0001, 1'b0, 0};

    model_mode = 1'b0; force_hit = 1'b0; force_word = '0; fixed_line = '0;

    // Reset state
    do_reset();
    chk("rst_ready_busy", 32'({a_req_ready, a_busy}), 32'b10);
    chk("rst_strobes", 32'({a_resp_valid, a_fill_en, a_inv_en, a_mem_read, a_resp_hit}), 32'd0);
    chk("rst_regs", a_resp_data | 32'(a_dp_addr) | 32'(a_mem_addr) | 32'(a_inv_index), 32'd0);
    chk("rst_counts", 32'({a_hit_count, a_miss_count}), 32'd0);

    // Flush with a coincident request
    do_flush(1'b1, 15'h0000);

    // Directed vector table
    ref_hits = 0; ref_misses = 0;
    for (int i = 0; i < 6; i++) begin
      force_hit  = vecs[i].hit;
      force_word = vecs[i].word;
      fixed_line = vecs[i].line;
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].delay, vecs[i].exp_hit,
              vecs[i].exp_data);
      if (vecs[i].exp_hit) ref_hits++; else ref_misses++;
      chk($sformatf("vec%0d_hit_cnt", i), 32'(a_hit_count), 32'(ref_hits));
      chk($sformatf("vec%0d_miss_cnt", i), 32'(a_miss_count), 32'(ref_misses));
    end

    // Backpressure, then a request held through RESP is taken only after the handshake
    wait_idle();
    force_hit = 1'b1; force_word = 32'h0F0F_0F0F;
    req_addr = 15'h0111; req_valid = 1'b1;
    tick();
    req_addr = 15'h0222;
    tick();
    chk("bp_resp_valid", 32'(a_resp_valid), 32'd1);
    begin
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (!a_resp_valid || a_resp_data != 32'h0F0F_0F0F || !a_resp_hit || a_req_ready ||
            a_dp_addr != 15'h0111) bad++;
      end
      chk("bp_hold_bad", 32'(bad), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_after_hs", 32'({a_req_ready, a_dp_addr}), 32'({1'b1, 15'h0111}));
    tick();
    req_valid = 1'b0;
    chk("bp_next_accept", 32'({a_busy, a_dp_addr}), 32'({1'b1, 15'h0222}));
    tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    ref_hits += 2;
    chk("bp_hit_cnt", 32'(a_hit_count), 32'(ref_hits));
    last_addr = 15'h0222;

    // Random reads against the cache model
    model_mode = 1'b1;
    do_flush(1'b0, last_addr);
    for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
    ref_hits = 0; ref_misses = 0;
    for (int n = 0; n < 60; n++) begin
      logic [14:0] addr;
      logic        eh;
      if (n == 30) begin
        do_flush(1'b0, last_addr);
        for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
        ref_hits = 0; ref_misses = 0;
      end
      addr = {3'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) addr = 15'($urandom);
      eh = ref_valid[addr[11:2]] && (ref_tag[addr[11:2]] == addr[14:12]);
      run_txn($sformatf("rnd%0d", n), addr, $urandom_range(0, 3), eh,
              gen_word(addr[14:2], addr[1:0]));
      if (eh) ref_hits++;
      else begin
        ref_misses++;
        ref_valid[addr[11:2]] = 1'b1;
        ref_tag[addr[11:2]]   = addr[14:12];
      end
      chk($sformatf("rnd%0d_hit_cnt", n), 32'(a_hit_count), 32'(ref_hits));
      chk($sformatf("rnd%0d_miss_cnt", n), 32'(a_miss_count), 32'(ref_misses));
    end
    model_mode = 1'b0;

    // Reset in the second MEM cycle of a MEM_LAT=4 miss
    do_reset();
    force_hit = 1'b0; fixed_line = {4{32'h5A5A_5A5A}};
    req_addr = 15'h0404; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rstmem_mem1", 32'(b_mem_read), 32'd1);
    tick();
    chk("rstmem_mem2", 32'({b_mem_read, b_miss_count}), 32'({1'b1, 4'd1}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmem_after", 32'({b_mem_read, b_req_ready, b_busy}), 32'b010);
    chk("rstmem_counts", 32'({b_hit_count, b_miss_count}), 32'd0);
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
        if (b_fill_en || b_resp_valid || b_mem_read) bad++;
        tick();
      end
      chk("rstmem_quiet_bad", 32'(bad), 32'd0);
    end

    // Back-to-back hits saturate the 4-bit counter
    do_reset();
    force_hit = 1'b1; force_word = 32'h0000_0042;
    req_addr = 15'h0808; req_valid = 1'b1; resp_ready = 1'b1;
    for (int h = 1; h <= 17; h++) begin
      tick();
      tick();
      tick();
      if (h == 15) chk("sat_at15", 32'(b_hit_count), 32'hF);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    chk("sat_hit_cnt", 32'(b_hit_count), 32'hF);
    chk("sat_miss_cnt", 32'(b_miss_count), 32'd0);
    chk("sat_wide_hit_cnt", 32'(a_hit_count), 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
